// File: rtl/s_lat_arb.sv
`default_nettype none
// ============================================================================
//  Module   : s_lat_arb
//  Purpose  : Round-robin arbiter in front of one shared latch register.
//             The winning requester's data is captured into odat. Each
//             capture can be followed by a number of enforced idle cycles
//             (HOLD state) before the next grant is allowed.
//  Revision : 1.0  initial release
// ============================================================================
module s_lat_arb #(
    parameter int              SIZE    = 8,
    parameter int              NREQ    = 4,
    parameter int              HOLD    = 2,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*SIZE-1:0]      idat,
    output logic [NREQ-1:0]           gnt,
    output logic [SIZE-1:0]           odat,
    output logic                      oval,
    output logic [$clog2(NREQ)-1:0]   osrc,
    output logic                      busy
);

    localparam int               c_PW       = $clog2(NREQ);
    localparam logic [0:0]       c_ST_IDLE  = 1'b0;
    localparam logic [0:0]       c_ST_HOLD  = 1'b1;
    // With no idle cycles requested the FSM never leaves IDLE.
    localparam logic [0:0]       c_ST_AFTER = (HOLD > 0) ? c_ST_HOLD : c_ST_IDLE;
    localparam logic [3:0]       c_HOLD_LD  = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;
    localparam logic [c_PW-1:0]  c_LAST     = c_PW'(NREQ - 1);
    localparam logic [c_PW:0]    c_NREQ_W   = (c_PW + 1)'(NREQ);

    // Registered state
    logic [0:0]       r_state;
    logic [3:0]       r_cnt;
    logic [c_PW-1:0]  r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic [SIZE-1:0]  r_odat;
    logic             r_oval;
    logic [c_PW-1:0]  r_osrc;

    // Next-state values
    logic [0:0]       w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [c_PW-1:0]  w_ptr_nxt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [SIZE-1:0]  w_odat_nxt;
    logic             w_oval_nxt;
    logic [c_PW-1:0]  w_osrc_nxt;

    // Arbitration helpers
    logic [NREQ-1:0]  w_elig;
    logic [c_PW-1:0]  w_rot [NREQ];
    logic [SIZE-1:0]  w_lane [NREQ];
    logic             w_found;
    logic [c_PW-1:0]  w_win;
    logic [SIZE-1:0]  w_win_dat;
    logic             w_cap;

    // A requester granted this cycle is masked so one request yields one grant.
    assign w_elig = req & ~r_gnt;

    // Split the flat data bus into lanes and build the rotated search order
    // starting at the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            logic [c_PW:0] w_sum;
            assign w_lane[gi] = idat[gi*SIZE +: SIZE];
            assign w_sum      = {1'b0, r_ptr} + (c_PW + 1)'(gi);
            assign w_rot[gi]  = (w_sum >= c_NREQ_W) ? c_PW'(w_sum - c_NREQ_W)
                                                    : w_sum[c_PW-1:0];
        end
    endgenerate

    // Pick the first eligible requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_elig[w_rot[k]]) begin
                w_found = 1'b1;
                w_win   = w_rot[k];
            end
        end
    end

    // Select only the winner's lane so unselected lanes never reach odat.
    always_comb begin
        w_win_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_PW'(i)) begin
                w_win_dat = w_lane[i];
            end
        end
    end

    assign w_cap = (r_state == c_ST_IDLE) && !freeze && w_found;

    // Next-state and capture decision; freeze only gates the IDLE capture.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_odat_nxt  = r_odat;
        w_oval_nxt  = 1'b0;
        w_osrc_nxt  = r_osrc;
        case (r_state)
            c_ST_IDLE: begin
                if (w_cap) begin
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_odat_nxt  = w_win_dat;
                    w_oval_nxt  = 1'b1;
                    w_osrc_nxt  = w_win;
                    w_ptr_nxt   = (w_win == c_LAST) ? '0 : w_win + c_PW'(1);
                    w_state_nxt = c_ST_AFTER;
                    w_cnt_nxt   = c_HOLD_LD;
                end
            end
            c_ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State register; reset overrides any capture or countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_odat  <= RST_VAL;
            r_oval  <= 1'b0;
            r_osrc  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_odat  <= w_odat_nxt;
            r_oval  <= w_oval_nxt;
            r_osrc  <= w_osrc_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign odat = r_odat;
    assign oval = r_oval;
    assign osrc = r_osrc;
    assign busy = (r_state == c_ST_HOLD);

endmodule
`default_nettype wire
